// File: rtl/fbra_channel_streamer.sv
// Ping-pong channel store feeding the FBRA pixel core one channel per clock,
// framing each pixel with a beamformer reset and DAS/DMAS sample shaping.
module fbra_channel_streamer #(
   parameter int CHANNELS  = 128,
   parameter int CNT_W     = 8,
   parameter int LEAD_DAS  = 2,
   parameter int LEAD_DMAS = 0,
   parameter int TAIL_DAS  = 3,
   parameter int TAIL_DMAS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode_in,
   input  logic              in_valid,
   input  logic [15:0]       in_data,
   output logic              in_ready,
   output logic              bf_rst,
   output logic              bf_mode,
   output logic [15:0]       chnl_data,
   output logic signed [1:0] sign,
   output logic              busy,
   output logic [15:0]       pix_cnt
);

   localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHANNELS - 1);
   localparam logic signed [1:0] POS = 2'sb01;
   localparam logic signed [1:0] NEG = 2'sb11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_LEAD,
      S_STREAM,
      S_TAIL
   } state_t;

   logic [15:0]       r_mem [2][CHANNELS];
   logic [1:0]        r_full;
   logic              r_wr_bank;
   logic [CNT_W-1:0]  r_wr_ptr;
   logic              r_in_ready;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rd_bank;
   logic              r_bf_rst;
   logic              r_bf_mode;
   logic [15:0]       r_chnl;
   logic signed [1:0] r_sign;
   logic              r_busy;
   logic [15:0]       r_pix_cnt;

   logic              w_wr_fire;
   logic              w_fill;
   logic              w_release;
   logic [1:0]        w_full_nxt;
   logic              w_wr_bank_nxt;
   logic [AW-1:0]     w_rd_addr;
   logic [15:0]       w_rd_word;
   logic              w_neg;
   logic [15:0]       w_mag;
   logic signed [1:0] w_sgn;
   logic [CNT_W-1:0]  w_lead;
   logic [CNT_W-1:0]  w_tail;

   assign w_wr_fire = in_valid & r_in_ready;
   assign w_fill    = w_wr_fire & (r_wr_ptr == LAST);
   assign w_release = (r_state == S_STREAM) && (r_cnt == LAST);

   // Release is applied before fill so a bank freed this cycle is visible
   // to the writer's ready flag on the very next clock.
   always_comb begin
      w_full_nxt = r_full;
      if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
      if (w_fill)    w_full_nxt[r_wr_bank] = 1'b1;
      w_wr_bank_nxt = r_wr_bank ^ w_fill;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_full     <= 2'b00;
         r_wr_bank  <= 1'b0;
         r_wr_ptr   <= '0;
         r_in_ready <= 1'b0;
      end else begin
         r_full     <= w_full_nxt;
         r_wr_bank  <= w_wr_bank_nxt;
         r_in_ready <= !w_full_nxt[w_wr_bank_nxt];
         if (w_wr_fire) begin
            if (w_fill) r_wr_ptr <= '0;
            else        r_wr_ptr <= r_wr_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_fire) r_mem[r_wr_bank][r_wr_ptr[AW-1:0]] <= in_data;
   end

   // Prefetch: the word loaded into the output register is the next channel.
   assign w_rd_addr = (r_state == S_STREAM) ? AW'(r_cnt + 1'b1) : '0;
   assign w_rd_word = r_mem[r_rd_bank][w_rd_addr];
   assign w_neg     = w_rd_word[15] & !r_bf_mode;

   always_comb begin
      w_mag = w_rd_word;
      w_sgn = POS;
      if (w_neg) begin
         w_sgn = NEG;
         if (w_rd_word == 16'h8000) w_mag = 16'h7FFF;
         else                       w_mag = 16'(~w_rd_word + 16'd1);
      end
   end

   assign w_lead = r_bf_mode ? CNT_W'(LEAD_DAS) : CNT_W'(LEAD_DMAS);
   assign w_tail = r_bf_mode ? CNT_W'(TAIL_DAS) : CNT_W'(TAIL_DMAS);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rd_bank <= 1'b0;
         r_bf_rst  <= 1'b1;
         r_bf_mode <= 1'b1;
         r_chnl    <= '0;
         r_sign    <= POS;
         r_busy    <= 1'b0;
         r_pix_cnt <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (r_full[r_rd_bank]) begin
                  r_state   <= S_RST;
                  r_bf_mode <= mode_in;
                  r_busy    <= 1'b1;
               end
            end
            S_RST: begin
               r_bf_rst <= 1'b0;
               r_cnt    <= '0;
               if (w_lead == '0) begin
                  r_state <= S_STREAM;
                  r_chnl  <= w_mag;
                  r_sign  <= w_sgn;
               end else begin
                  r_state <= S_LEAD;
                  r_chnl  <= '0;
                  r_sign  <= POS;
               end
            end
            S_LEAD: begin
               if (r_cnt == w_lead - 1'b1) begin
                  r_state <= S_STREAM;
                  r_cnt   <= '0;
                  r_chnl  <= w_mag;
                  r_sign  <= w_sgn;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STREAM: begin
               if (r_cnt == LAST) begin
                  r_state   <= S_TAIL;
                  r_cnt     <= '0;
                  r_chnl    <= '0;
                  r_sign    <= POS;
                  r_rd_bank <= ~r_rd_bank;
                  r_pix_cnt <= r_pix_cnt + 16'd1;
               end else begin
                  r_cnt  <= r_cnt + 1'b1;
                  r_chnl <= w_mag;
                  r_sign <= w_sgn;
               end
            end
            S_TAIL: begin
               if (r_cnt + 1'b1 >= w_tail) begin
                  r_cnt    <= '0;
                  r_bf_rst <= 1'b1;
                  if (r_full[r_rd_bank]) begin
                     r_state   <= S_RST;
                     r_bf_mode <= mode_in;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_bf_rst <= 1'b1;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign bf_rst    = r_bf_rst;
   assign bf_mode   = r_bf_mode;
   assign chnl_data = r_chnl;
   assign sign      = r_sign;
   assign busy      = r_busy;
   assign pix_cnt   = r_pix_cnt;

endmodule

// File: tb/tb_fbra_channel_streamer.sv
// Directed bench for fbra_channel_streamer: DAS/DMAS framing, saturation,
// back-to-back ping-pong flow, mid-pixel mode change and mid-stream reset.
module tb_fbra_channel_streamer;

   logic              clk = 1'b0;
   logic              rst;
   logic              mode_in;
   logic              in_valid;
   logic [15:0]       in_data;
   logic              in_ready;
   logic              bf_rst;
   logic              bf_mode;
   logic [15:0]       chnl_data;
   logic signed [1:0] sign;
   logic              busy;
   logic [15:0]       pix_cnt;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [15:0] din [384];
   logic [15:0] ed  [384];
   logic [1:0]  es  [384];

   fbra_channel_streamer dut (
      .clk(clk), .rst(rst), .mode_in(mode_in),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .bf_rst(bf_rst), .bf_mode(bf_mode), .chnl_data(chnl_data),
      .sign(sign), .busy(busy), .pix_cnt(pix_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] d, output int st);
      st = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      while (in_ready !== 1'b1 && st < 1000) begin
         @(negedge clk);
         st++;
      end
      if (st >= 1000) chk("push_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic write_pixel(input int off);
      int st;
      for (int k = 0; k < 128; k++) push(din[off+k], st);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_frame(input string tag, output int t);
      int n = 0;
      while (bf_rst !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk({tag, "_start"}, 32'(bf_rst), 32'd0);
      t = cyc;
   endtask

   task automatic check_pixel(input logic m, input int off,
                              input string tag, output int t);
      int lead = m ? 2 : 0;
      int tail = m ? 3 : 8;
      wait_frame(tag, t);
      for (int i = 0; i < lead; i++) begin
         chk({tag, "_lead"}, 32'({bf_mode, bf_rst, sign, chnl_data}),
             32'({m, 1'b0, 2'b01, 16'h0}));
         @(negedge clk);
      end
      for (int k = 0; k < 128; k++) begin
         chk({tag, "_ch"}, 32'({bf_mode, bf_rst, sign, chnl_data}),
             32'({m, 1'b0, es[off+k], ed[off+k]}));
         @(negedge clk);
      end
      for (int i = 0; i < tail; i++) begin
         chk({tag, "_tail"}, 32'({bf_mode, bf_rst, sign, chnl_data}),
             32'({m, 1'b0, 2'b01, 16'h0}));
         @(negedge clk);
      end
      chk({tag, "_end"}, 32'(bf_rst), 32'd1);
   endtask

   initial begin
      int st, first, flen, t0, t1, t2, n2;
      rst      = 1'b0;
      mode_in  = 1'b1;
      in_valid = 1'b0;
      in_data  = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_bf_rst", 32'(bf_rst), 32'd1);
      chk("rst_bf_mode", 32'(bf_mode), 32'd1);
      chk("rst_chnl", 32'(chnl_data), 32'd0);
      chk("rst_sign", 32'(sign), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pix", 32'(pix_cnt), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(in_ready), 32'd1);

      // DAS ramp
      for (int k = 0; k < 128; k++) begin
         din[k] = 16'(k);
         ed[k]  = 16'(k);
         es[k]  = 2'b01;
      end
      mode_in = 1'b1;
      write_pixel(0);
      check_pixel(1'b1, 0, "das", t0);
      chk("das_pix", 32'(pix_cnt), 32'd1);
      chk("das_idle_busy", 32'(busy), 32'd0);

      // DMAS alternating +/-100
      for (int k = 0; k < 128; k++) begin
         din[k] = k[0] ? 16'hFF9C : 16'd100;
         ed[k]  = 16'd100;
         es[k]  = k[0] ? 2'b11 : 2'b01;
      end
      mode_in = 1'b0;
      write_pixel(0);
      check_pixel(1'b0, 0, "dmas_alt", t0);
      chk("dmas_alt_pix", 32'(pix_cnt), 32'd2);

      // DMAS extremes
      for (int k = 0; k < 128; k++) begin
         unique case (k % 3)
            0: begin din[k] = 16'h8000; ed[k] = 16'h7FFF; es[k] = 2'b11; end
            1: begin din[k] = 16'h0000; ed[k] = 16'h0000; es[k] = 2'b01; end
            default: begin din[k] = 16'h7FFF; ed[k] = 16'h7FFF; es[k] = 2'b01; end
         endcase
      end
      write_pixel(0);
      check_pixel(1'b0, 0, "dmas_edge", t0);
      chk("dmas_edge_pix", 32'(pix_cnt), 32'd3);

      // mode toggle mid-pixel, new mode on next pixel
      for (int k = 0; k < 128; k++) begin
         din[k]     = 16'(k - 64);
         din[128+k] = 16'(k - 64);
         ed[k]      = 16'(k - 64);
         es[k]      = 2'b01;
         ed[128+k]  = (k < 64) ? 16'(64 - k) : 16'(k - 64);
         es[128+k]  = (k < 64) ? 2'b11 : 2'b01;
      end
      mode_in = 1'b1;
      write_pixel(0);
      fork
         check_pixel(1'b1, 0, "tog_a", t0);
         begin
            wait_frame("tog_sync", n2);
            repeat (52) @(negedge clk);
            mode_in = 1'b0;
         end
      join
      write_pixel(128);
      check_pixel(1'b0, 128, "tog_b", t1);
      chk("tog_pix", 32'(pix_cnt), 32'd5);

      // back-to-back three DAS pixels
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 384; i++) begin
         din[i] = 16'(1000 + i);
         ed[i]  = 16'(1000 + i);
         es[i]  = 2'b01;
      end
      mode_in = 1'b1;
      first = -1;
      flen  = 0;
      fork
         begin
            for (int i = 0; i < 384; i++) begin
               push(din[i], st);
               if (st > 0 && first < 0) begin
                  first = i;
                  flen  = st;
               end
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            check_pixel(1'b1, 0, "b2b_0", t0);
            check_pixel(1'b1, 128, "b2b_1", t1);
            check_pixel(1'b1, 256, "b2b_2", t2);
         end
      join
      chk("b2b_stall_idx", 32'(first), 32'd256);
      chk("b2b_stall_len", 32'(flen), 32'd4);
      chk("b2b_period_01", 32'(t1 - t0), 32'd134);
      chk("b2b_period_12", 32'(t2 - t1), 32'd134);
      chk("b2b_pix", 32'(pix_cnt), 32'd3);

      // reset mid-stream at channel 60
      for (int k = 0; k < 128; k++) din[k] = 16'(2 * k + 1);
      write_pixel(0);
      wait_frame("mid_sync", t0);
      repeat (62) @(negedge clk);
      chk("pre_rst_ch60", 32'(chnl_data), 32'd121);
      rst = 1'b0;
      #1;
      chk("mid_rst_bf_rst", 32'(bf_rst), 32'd1);
      chk("mid_rst_chnl", 32'(chnl_data), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_pix", 32'(pix_cnt), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rel_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 128; k++) begin
         din[k] = 16'(16'hC000 + k);
         ed[k]  = 16'(16'hC000 + k);
         es[k]  = 2'b01;
      end
      write_pixel(0);
      check_pixel(1'b1, 0, "post_rst", t0);
      chk("post_rst_pix", 32'(pix_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
